// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states, default register width,
// and the ID/EX control-word bubble constant.
package pipeline_pkg;

    // Hazard controller states.
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    // Default register-address width.
    localparam int DEF_REG_BITS = 5;

    // Width of the stall down-counter; this limits LOAD_LAT to 1..15.
    localparam int REMAIN_BITS  = 4;

    // ID/EX control word and the all-zero bubble placed on the mux msb input.
    localparam int                   CTRL_BITS = 7;
    localparam logic [CTRL_BITS-1:0] CTRL_NOP  = 7'b0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard bus: decode/EX operand info in, pipeline enables out.
interface hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int REG_BITS = DEF_REG_BITS,
    parameter int CNT_BITS = 16
);
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_uses_rt;
    logic                ex_memread;
    logic [REG_BITS-1:0] ex_rd;
    logic                branch_taken;
    logic                pc_write;
    logic                ifid_write;
    logic                ifid_flush;
    logic                bubble_sel;
    logic [CNT_BITS-1:0] stall_cycles;

    // Pipeline side: supplies operand info, consumes enables.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, branch_taken,
        input  pc_write, ifid_write, ifid_flush, bubble_sel, stall_cycles
    );

    // Hazard controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, branch_taken,
        output pc_write, ifid_write, ifid_flush, bubble_sel, stall_cycles
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard and branch-flush controller for the ID stage.
// Mealy outputs: a hazard or taken branch affects the enables in the same cycle.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_BITS = DEF_REG_BITS,
    parameter int LOAD_LAT = 1,
    parameter int CNT_BITS = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz_if
);
    logic [REG_BITS-1:0]    id_rs;
    logic [REG_BITS-1:0]    id_rt;
    logic [REG_BITS-1:0]    ex_rd;
    logic                   hz;
    state_e                 state_q;
    state_e                 state_d;
    logic [REMAIN_BITS-1:0] remain_q;
    logic [REMAIN_BITS-1:0] remain_d;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   ifid_flush;
    logic                   bubble_sel;
    logic [CNT_BITS-1:0]    stall_count;

    assign id_rs = hz_if.id_rs;
    assign id_rt = hz_if.id_rt;
    assign ex_rd = hz_if.ex_rd;

    // Load in EX writing a register the ID instruction reads; r0 never hazards.
    always_comb begin
        hz = hz_if.ex_memread && (ex_rd != '0) &&
             ((ex_rd == id_rs) || (hz_if.id_uses_rt && (ex_rd == id_rt)));
    end

    // Next-state and output decode; branch beats stall, reset beats both.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        bubble_sel = 1'b0;

        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
        end else if (hz_if.branch_taken) begin
            ifid_flush = 1'b1;
            bubble_sel = 1'b1;
            state_d    = RUN;
            remain_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        bubble_sel = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d  = STALL;
                            remain_d = REMAIN_BITS'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    // Hold regardless of hz: EX still shows the same load.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    bubble_sel = 1'b1;
                    remain_d   = remain_q - 1'b1;
                    if (remain_q == REMAIN_BITS'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d  = RUN;
                    remain_d = '0;
                end
            endcase
        end
    end

    // State and stall down-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Stall-cycle statistics: one count per frozen-PC edge.
    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_write & ~reset),
        .count (stall_count)
    );

    assign hz_if.pc_write     = pc_write;
    assign hz_if.ifid_write   = ifid_write;
    assign hz_if.ifid_flush   = ifid_flush;
    assign hz_if.bubble_sel   = bubble_sel;
    assign hz_if.stall_cycles = stall_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3,
// and a 4-bit counter) driven from the same stimulus.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_memread, branch_taken;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_BITS(5), .CNT_BITS(16)) if_l1  ();
    hazard_ctrl_if #(.REG_BITS(5), .CNT_BITS(16)) if_l3  ();
    hazard_ctrl_if #(.REG_BITS(5), .CNT_BITS(4))  if_sat ();

    assign if_l1.id_rs         = id_rs;
    assign if_l1.id_rt         = id_rt;
    assign if_l1.id_uses_rt    = id_uses_rt;
    assign if_l1.ex_memread    = ex_memread;
    assign if_l1.ex_rd         = ex_rd;
    assign if_l1.branch_taken  = branch_taken;
    assign if_l3.id_rs         = id_rs;
    assign if_l3.id_rt         = id_rt;
    assign if_l3.id_uses_rt    = id_uses_rt;
    assign if_l3.ex_memread    = ex_memread;
    assign if_l3.ex_rd         = ex_rd;
    assign if_l3.branch_taken  = branch_taken;
    assign if_sat.id_rs        = id_rs;
    assign if_sat.id_rt        = id_rt;
    assign if_sat.id_uses_rt   = id_uses_rt;
    assign if_sat.ex_memread   = ex_memread;
    assign if_sat.ex_rd        = ex_rd;
    assign if_sat.branch_taken = branch_taken;

    hazard_ctrl #(.REG_BITS(5), .LOAD_LAT(1), .CNT_BITS(16)) u_l1 (
        .clk(clk), .reset(reset), .hz_if(if_l1));
    hazard_ctrl #(.REG_BITS(5), .LOAD_LAT(3), .CNT_BITS(16)) u_l3 (
        .clk(clk), .reset(reset), .hz_if(if_l3));
    hazard_ctrl #(.REG_BITS(5), .LOAD_LAT(1), .CNT_BITS(4))  u_sat (
        .clk(clk), .reset(reset), .hz_if(if_sat));

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       uses_rt, memread, br;
        logic       pc_w, ifid_w, flush, bubble;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                          input logic mr, input logic [4:0] rd, input logic br);
        id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_memread = mr; ex_rd = rd; branch_taken = br;
    endtask

    task automatic idle();
        set_in(5'd4, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    logic exp_pc3 [5];

    initial begin
        idle();
        reset = 1'b1;

        // Reset outputs override even a branch request.
        branch_taken = 1'b1;
        @(negedge clk);
        check("rst_pc_write",   if_l1.pc_write,     0);
        check("rst_ifid_write", if_l1.ifid_write,   0);
        check("rst_ifid_flush", if_l1.ifid_flush,   0);
        check("rst_bubble",     if_l1.bubble_sel,   1);
        check("rst_stall_cnt",  if_l1.stall_cycles, 0);
        cyc();
        branch_taken = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_pc_write", if_l1.pc_write, 1);
        cyc();

        // Combinational vectors against the LOAD_LAT=1 instance.
        vecs[0] = '{5'd4,  5'd5, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'd4,  5'd5, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{5'd4,  5'd5, 5'd5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'd7,  5'd5, 5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{5'd7,  5'd5, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{5'd4,  5'd5, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{5'd4,  5'd5, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{5'd31, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        begin
            int exp_cnt = 0;
            for (int i = 0; i < 9; i++) begin
                set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt,
                       vecs[i].memread, vecs[i].rd, vecs[i].br);
                @(negedge clk);
                check($sformatf("v%0d_pc_write", i),   if_l1.pc_write,   vecs[i].pc_w);
                check($sformatf("v%0d_ifid_write", i), if_l1.ifid_write, vecs[i].ifid_w);
                check($sformatf("v%0d_ifid_flush", i), if_l1.ifid_flush, vecs[i].flush);
                check($sformatf("v%0d_bubble", i),     if_l1.bubble_sel, vecs[i].bubble);
                if (!vecs[i].pc_w) exp_cnt++;
                cyc();
                idle();
            end
            @(negedge clk);
            check("vec_stall_cnt", if_l1.stall_cycles, exp_cnt);
        end

        // LOAD_LAT=3: one hazard cycle gives exactly three stalled cycles.
        exp_pc3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        set_in(5'd7, 5'd5, 1'b0, 1'b1, 5'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("l3_c%0d_pc_write", i), if_l3.pc_write,   exp_pc3[i]);
            check($sformatf("l3_c%0d_bubble", i),   if_l3.bubble_sel, !exp_pc3[i]);
            cyc();
            idle();
        end
        check("l3_stall_cnt", if_l3.stall_cycles, 3);

        // Branch during a stall: flush wins and the stall is abandoned.
        do_reset();
        set_in(5'd7, 5'd5, 1'b0, 1'b1, 5'd7, 1'b0);
        @(negedge clk);
        check("br_c0_pc_write", if_l3.pc_write, 0);
        cyc();
        idle();
        branch_taken = 1'b1;
        @(negedge clk);
        check("br_c1_flush",    if_l3.ifid_flush, 1);
        check("br_c1_pc_write", if_l3.pc_write,   1);
        check("br_c1_bubble",   if_l3.bubble_sel, 1);
        cyc();
        branch_taken = 1'b0;
        @(negedge clk);
        check("br_c2_pc_write", if_l3.pc_write,     1);
        check("br_c2_bubble",   if_l3.bubble_sel,   0);
        check("br_c2_flush",    if_l3.ifid_flush,   0);
        check("br_stall_cnt",   if_l3.stall_cycles, 1);
        cyc();

        // Reset in the middle of a stall clears everything asynchronously.
        do_reset();
        set_in(5'd7, 5'd5, 1'b0, 1'b1, 5'd7, 1'b0);
        cyc();
        idle();
        check("mid_stall_cnt", if_l3.stall_cycles, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pc_write",   if_l3.pc_write,     0);
        check("arst_ifid_write", if_l3.ifid_write,   0);
        check("arst_bubble",     if_l3.bubble_sel,   1);
        check("arst_stall_cnt",  if_l3.stall_cycles, 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("arst_rel_pc_write", if_l3.pc_write,   1);
        check("arst_rel_bubble",   if_l3.bubble_sel, 0);
        cyc();

        // Saturation: 20 isolated hazards on a 4-bit counter stop at 15.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(5'd4, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
            cyc();
            idle();
            cyc();
        end
        check("sat_cnt_4bit", if_sat.stall_cycles, 15);
        check("sat_cnt_16bit", if_l1.stall_cycles, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Load-use hazard and flush controller for the ID stage of the pipeline. Detects when the instruction in ID reads a register that a load in EX has not yet produced. On a hazard it freezes PC and IF/ID for one or more cycles, and drives the select of the ID/EX control-word mux so that a zero control word (bubble) goes into EX. A taken branch overrides any stall: it flushes IF/ID and bubbles EX. A saturating counter records total stall cycles for performance checks.

## Interface
- REG_BITS, 5: register-address width.
- LOAD_LAT, 1: stall cycles per load-use hazard (1..15); memory latency plus one.
- CNT_BITS, 16: width of the stall-cycle statistics counter.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- id_rs  input  REG_BITS  first source register of the instruction in ID.
- id_rt  input  REG_BITS  second source register of the instruction in ID.
- id_uses_rt  input  1  ID instruction actually reads id_rt.
- ex_memread  input  1  instruction in EX is a load.
- ex_rd  input  REG_BITS  destination register of the EX instruction.
- branch_taken  input  1  branch resolved taken this cycle; flush request.
- pc_write  output  1  PC register enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  clear IF/ID to NOP on this edge.
- bubble_sel  output  1  drives the ID/EX control mux `dec`:
  - 1 selects the msb input, tied to the all-zero bubble.
  - 0 selects the lsb input, the decoded control word.
- stall_cycles  output  CNT_BITS  saturating count of stalled cycles since reset.

## Operation
- Hazard detect (combinational): hz = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))). Register 0 never hazards.
- States are RUN and STALL. There is a 4-bit down-counter `remain`.
- RUN with hz=0: pc_write=1, ifid_write=1, bubble_sel=0, ifid_flush=0.
- RUN with hz=1: stall this cycle (pc_write=0, ifid_write=0, bubble_sel=1).
  - If LOAD_LAT>1: go to STALL with remain=LOAD_LAT-1.
  - Otherwise stay in RUN.
- STALL: outputs stalled as above, regardless of hz. remain decrements each cycle. When remain==1, go to RUN on the next edge.
- After a stall, hz is naturally 0 because the load has left EX. The block does not re-stall on stale EX inputs once in STALL.
- branch_taken=1 has top priority in any state:
  - pc_write=1, ifid_write=1, ifid_flush=1, bubble_sel=1.
  - Next state is RUN with remain=0. An ongoing stall is abandoned.
- stall_cycles increments on every edge where pc_write=0 and reset=0. It saturates at all-ones and never wraps.
- While reset=1: pc_write=0, ifid_write=0, ifid_flush=0, bubble_sel=1.
- Reset values: state=RUN, remain=0, stall_cycles=0.

## Timing
- Outputs are Mealy: they depend combinationally on inputs in the same cycle, with zero latency from hz or branch_taken.
- Total stall per hazard is exactly LOAD_LAT cycles of pc_write=0, counting the detection cycle.
- State, remain and stall_cycles update on the rising clk edge.
- Asserting reset mid-stall clears state immediately (asynchronous). Normal RUN outputs resume on the first cycle after reset deasserts.
- hz and branch_taken in the same cycle: the branch wins. No stall is entered and stall_cycles does not increment.

## Structure
- Shared package `pipeline_pkg` holds:
  - state enum RUN/STALL;
  - REG_BITS default;
  - CTRL_BITS=7;
  - bubble constant CTRL_NOP = 7'b0, driven onto the mux msb input at ID.
- One sub-module, `sat_counter` (parameter width; inputs clk, reset, inc; output count), implements stall_cycles.

## Test plan
- No hazard: LOAD_LAT=1; ex_memread=1, ex_rd=3, id_rs=4, id_rt=5, id_uses_rt=1 → pc_write=1, bubble_sel=0, stall_cycles stays 0.
- Load-use on rt, LOAD_LAT=1:
  - Stimulus: ex_rd=5, id_rt=5, id_uses_rt=1; next cycle ex_memread=0.
  - Response: exactly 1 cycle of pc_write=0, ifid_write=0, bubble_sel=1; stall_cycles=1.
  - Repeat with id_uses_rt=0 → no stall.
- Multi-cycle, LOAD_LAT=3: ex_rd=7=id_rs for one cycle → pc_write low for exactly 3 consecutive cycles, then RUN; stall_cycles=3.
- Branch priority:
  - LOAD_LAT=3; hazard at cycle 0, branch_taken=1 at cycle 1.
  - Response at cycle 1: ifid_flush=1, pc_write=1, bubble_sel=1.
  - Cycle 2 is in RUN; stall_cycles=1.
- Register 0 and reset:
  - ex_rd=0=id_rs with ex_memread=1 → no stall.
  - Assert reset during a LOAD_LAT=3 stall → outputs go to their reset values asynchronously; stall_cycles=0.
  - After release: RUN, pc_write=1.
- Saturation: CNT_BITS=4; 20 separate LOAD_LAT=1 hazards → stall_cycles holds at 15.
